multichannel_countdown_timer: RTL and testbench
===============================================

# multichannel_countdown_timer

- Parametrised, multi-channel successor to the single fixed countdown: NUM_CH independent down-counters, each with a runtime-programmable period.
- Each channel has one-shot or auto-reload mode, pause/resume, stop, a sticky time-out level and a single-cycle expiry pulse.
- Sits between the input sampler and the decode FSM; supplies dot/dash/gap timing windows for the Morse decoder.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels.
- WIDTH, 27, counter and period width in bits; 27 covers 100_000_000 ticks.
- PRESCALE, 100, clock cycles per count tick; used only with TIMER_PRESCALE_EN.

Ports:
- clk_100Mhz  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- start  in  NUM_CH  per-channel: latch period and begin counting.
- stop  in  NUM_CH  per-channel: abort, return to IDLE.
- pause  in  NUM_CH  per-channel level: hold count while high.
- auto_reload  in  NUM_CH  per-channel mode, sampled on start: 1 = periodic, 0 = one-shot.
- period_in  in  NUM_CH*WIDTH  flattened periods; channel i uses bits [i*WIDTH +: WIDTH].
- count_out  out  NUM_CH*WIDTH  flattened current count values.
- running  out  NUM_CH  channel is in RUN or PAUSED.
- time_out  out  NUM_CH  sticky level: one-shot channel has expired.
- expire_pulse  out  NUM_CH  one-cycle pulse on each expiry.

## Operation
- Per-channel state machine: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- Control priority per channel: reset > start > stop > pause.
- Reset: all channels go to IDLE.
  - count, reload register and mode register clear to 0.
  - running, time_out and expire_pulse are 0.
  - Prescaler clears to 0.
- start (any state): reload register <= period slice, mode <= auto_reload bit, count <= period, state <= RUN.
  - time_out clears.
  - Restarting a running channel is legal and discards the old count.
- start with period 0: state goes to EXPIRED on the next edge with expire_pulse and time_out asserted. No reload occurs, even in auto mode.
- RUN, on each tick with pause low, count decrements by 1.
  - When count = 1 and decrementing, one-shot: count <= 0, state <= EXPIRED, time_out <= 1, expire_pulse <= 1.
  - When count = 1 and decrementing, auto-reload: count <= reload, stays RUN, expire_pulse <= 1.
- RUN with pause high: state <= PAUSED, count frozen. PAUSED with pause low: back to RUN, decrementing resumes on the next tick.
- stop: state <= IDLE, count <= 0, time_out <= 0; no pulse.
- EXPIRED holds count = 0 and time_out = 1 until start, stop or reset.
- Decrement is unsigned in WIDTH bits. The count never wraps below 0.
- Channels are fully independent. Simultaneous events on different channels are each handled in the same cycle.

## Timing
- Start sampled at edge E0 gives count_out = P after E0. The count reaches 0 and expire_pulse is high after edge E0+P (no prescale).
- Expiry period is exactly P ticks in both modes. In auto mode, count sequence P, P-1, …, 1, P, …; the pulse coincides with count_out = P after reload.
- expire_pulse is high for exactly one clk_100Mhz cycle per expiry, including under prescale.
- Pause latency: pause high at edge E freezes the count from E onward. Each paused cycle extends expiry by one tick.
- running rises the cycle after start and falls the cycle after expiry (one-shot) or stop.

## Configuration
- TIMER_PRESCALE_EN defined:
  - A shared free-running prescaler counts 0..PRESCALE-1.
  - One tick is issued when it wraps, i.e. one tick per PRESCALE cycles.
  - Channels decrement only on tick cycles; start, stop and pause still act on every cycle.
  - The prescaler is reset only by reset, not by start.
- TIMER_PRESCALE_EN undefined: every cycle is a tick, and PRESCALE is ignored with no prescaler logic.

## Test plan
- Reset mid-count with channel 0 running at count 37 -> next cycle count 0, running/time_out/expire_pulse all 0.
- Channel 1, one-shot, P=5 -> count 5,4,3,2,1,0; single expire_pulse when count = 0; time_out stays 1 for 20 further cycles.
- Channel 2, auto-reload, P=3 for 12 cycles -> expire_pulse every 3 cycles (4 pulses); running stays 1.
- Channel 0, P=10, pause held 4 cycles at count 6 -> expiry at cycle 14 not 10; count holds 6 during pause.
- Start and stop together, plus start with P=0 on channel 3 -> start wins (count = P); P=0 gives EXPIRED and one pulse next cycle.
- TIMER_PRESCALE_EN with PRESCALE=4, P=3 -> expiry 12±3 cycles after start; expire_pulse exactly one clk cycle wide.

Source files
------------

// File: rtl/multichannel_countdown_timer.sv
// NUM_CH independent countdown channels (one-shot/auto-reload, pause, stop), optional shared tick prescaler via TIMER_PRESCALE_EN.
// Latency: all outputs registered; count_out = P one cycle after start, expiry P ticks after start.
// Backpressure: none; start/stop/pause act every cycle, decrements only on tick cycles.
module multichannel_countdown_timer #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 27,
    parameter int PRESCALE = 100
) (
    input  logic                    clk_100Mhz,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       pause,
    input  logic [NUM_CH-1:0]       auto_reload,
    input  logic [NUM_CH*WIDTH-1:0] period_in,
    output logic [NUM_CH*WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       time_out,
    output logic [NUM_CH-1:0]       expire_pulse
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    logic tick;

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    // Free-running and shared; start does not realign it, so the first tick may come early.
    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == PRESC_LAST);
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] reload;
        logic             mode;
        logic             running_r;
        logic             time_out_r;
        logic             pulse_r;
        logic [WIDTH-1:0] period;

        assign period = period_in[i*WIDTH +: WIDTH];

        always_ff @(posedge clk_100Mhz) begin
            if (reset) begin
                state      <= IDLE;
                count      <= '0;
                reload     <= '0;
                mode       <= 1'b0;
                running_r  <= 1'b0;
                time_out_r <= 1'b0;
                pulse_r    <= 1'b0;
            end else begin
                pulse_r <= 1'b0;
                if (start[i]) begin
                    reload <= period;
                    mode   <= auto_reload[i];
                    // A zero period expires immediately and never reloads.
                    if (period == '0) begin
                        state      <= EXPIRED;
                        count      <= '0;
                        running_r  <= 1'b0;
                        time_out_r <= 1'b1;
                        pulse_r    <= 1'b1;
                    end else begin
                        state      <= RUN;
                        count      <= period;
                        running_r  <= 1'b1;
                        time_out_r <= 1'b0;
                    end
                end else if (stop[i]) begin
                    state      <= IDLE;
                    count      <= '0;
                    running_r  <= 1'b0;
                    time_out_r <= 1'b0;
                end else begin
                    case (state)
                        RUN, PAUSED: begin
                            if (pause[i]) begin
                                state <= PAUSED;
                            end else begin
                                // Resume edge already counts, so each paused cycle costs exactly one tick.
                                state <= RUN;
                                if (tick) begin
                                    if (count <= WIDTH'(1)) begin
                                        pulse_r <= 1'b1;
                                        if (mode) begin
                                            count <= reload;
                                        end else begin
                                            count      <= '0;
                                            state      <= EXPIRED;
                                            running_r  <= 1'b0;
                                            time_out_r <= 1'b1;
                                        end
                                    end else begin
                                        count <= count - 1'b1;
                                    end
                                end
                            end
                        end
                        EXPIRED: begin
                            count      <= '0;
                            time_out_r <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign count_out[i*WIDTH +: WIDTH] = count;
        assign running[i]                  = running_r;
        assign time_out[i]                 = time_out_r;
        assign expire_pulse[i]             = pulse_r;
    end

endmodule

// File: tb/tb_multichannel_countdown_timer.sv
// Scoreboard bench: a driver advances a per-channel countdown model each cycle and queues the expected outputs; a monitor compares.
module tb_multichannel_countdown_timer;

    localparam int NUM_CH   = 4;
    localparam int WIDTH    = 27;
    localparam int PRESCALE = 4;

    logic                    clk_100Mhz = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_CH-1:0]       start = '0;
    logic [NUM_CH-1:0]       stop = '0;
    logic [NUM_CH-1:0]       pause = '0;
    logic [NUM_CH-1:0]       auto_reload = '0;
    logic [NUM_CH*WIDTH-1:0] period_in = '0;
    logic [NUM_CH*WIDTH-1:0] count_out;
    logic [NUM_CH-1:0]       running;
    logic [NUM_CH-1:0]       time_out;
    logic [NUM_CH-1:0]       expire_pulse;

    multichannel_countdown_timer #(
        .NUM_CH  (NUM_CH),
        .WIDTH   (WIDTH),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk_100Mhz  (clk_100Mhz),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .period_in   (period_in),
        .count_out   (count_out),
        .running     (running),
        .time_out    (time_out),
        .expire_pulse(expire_pulse)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    typedef struct packed {
        logic [NUM_CH*WIDTH-1:0] cnt;
        logic [NUM_CH-1:0]       run;
        logic [NUM_CH-1:0]       to;
        logic [NUM_CH-1:0]       pl;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   mon_cycle = 0;

    // Reference model: remaining ticks, reload value and mode per channel.
    int m_cnt[NUM_CH];
    int m_rel[NUM_CH];
    bit m_auto[NUM_CH];
    bit m_run[NUM_CH];
    bit m_to[NUM_CH];
    bit m_pl[NUM_CH];
    int m_edges = 0;

    function automatic logic [NUM_CH*WIDTH-1:0] per_of(input int ch, input int p);
        logic [NUM_CH*WIDTH-1:0] v;
        v = '0;
        v[ch*WIDTH +: WIDTH] = WIDTH'(p);
        return v;
    endfunction

    task automatic step(input logic r, input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp,
                        input logic [NUM_CH-1:0] pa, input logic [NUM_CH-1:0] ar,
                        input logic [NUM_CH*WIDTH-1:0] per);
        exp_t e;
        bit   tick;
        @(negedge clk_100Mhz);
        reset       = r;
        start       = st;
        stop        = sp;
        pause       = pa;
        auto_reload = ar;
        period_in   = per;
        if (r) begin
            m_edges = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_cnt[ch] = 0; m_rel[ch] = 0; m_auto[ch] = 0;
                m_run[ch] = 0; m_to[ch] = 0; m_pl[ch] = 0;
            end
        end else begin
            m_edges++;
`ifdef TIMER_PRESCALE_EN
            tick = (m_edges % PRESCALE) == 0;
`else
            tick = 1'b1;
`endif
            for (int ch = 0; ch < NUM_CH; ch++) begin
                int p;
                p = int'(per[ch*WIDTH +: WIDTH]);
                m_pl[ch] = 0;
                if (st[ch]) begin
                    m_rel[ch]  = p;
                    m_auto[ch] = ar[ch];
                    m_cnt[ch]  = p;
                    m_run[ch]  = (p != 0);
                    m_to[ch]   = (p == 0);
                    m_pl[ch]   = (p == 0);
                end else if (sp[ch]) begin
                    m_cnt[ch] = 0; m_run[ch] = 0; m_to[ch] = 0;
                end else if (m_run[ch] && !pa[ch] && tick) begin
                    m_cnt[ch] = m_cnt[ch] - 1;
                    if (m_cnt[ch] == 0) begin
                        m_pl[ch] = 1;
                        if (m_auto[ch]) m_cnt[ch] = m_rel[ch];
                        else begin
                            m_run[ch] = 0;
                            m_to[ch]  = 1;
                        end
                    end
                end
            end
        end
        e = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e.cnt[ch*WIDTH +: WIDTH] = WIDTH'(m_cnt[ch]);
            e.run[ch] = m_run[ch];
            e.to[ch]  = m_to[ch];
            e.pl[ch]  = m_pl[ch];
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, '0, '0);
    endtask

    // Monitor: one expected snapshot per clock edge, compared per channel.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_100Mhz);
            #1;
            mon_cycle++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    logic [WIDTH-1:0] ac, ec;
                    ac = count_out[ch*WIDTH +: WIDTH];
                    ec = e.cnt[ch*WIDTH +: WIDTH];
                    checks++;
                    if (ac === ec && running[ch] === e.run[ch] && time_out[ch] === e.to[ch]
                        && expire_pulse[ch] === e.pl[ch]) begin
                        passed++;
                    end else begin
                        $display("FAIL ch%0d cycle %0d: got count=%0d running=%b time_out=%b pulse=%b, want count=%0d running=%b time_out=%b pulse=%b",
                                 ch, mon_cycle, ac, running[ch], time_out[ch], expire_pulse[ch],
                                 ec, e.run[ch], e.to[ch], e.pl[ch]);
                    end
                end
            end
        end
    end

    initial begin
        bit [NUM_CH-1:0] pa_lvl;
        pa_lvl = '0;
        for (int k = 0; k < 3; k++) step(1'b1, '0, '0, '0, '0, '0);

        // Reset while channel 0 is at 37.
        step(1'b0, 4'b0001, '0, '0, '0, per_of(0, 40));
        idle(3);
        step(1'b1, '0, '0, '0, '0, '0);
        idle(2);

        // One-shot P=5 on channel 1, then hold in time-out.
        step(1'b0, 4'b0010, '0, '0, '0, per_of(1, 5));
        idle(25);

        // Auto-reload P=3 on channel 2 for 12 cycles.
        step(1'b0, 4'b0100, '0, '0, 4'b0100, per_of(2, 3));
        idle(12);
        step(1'b0, '0, 4'b0100, '0, '0, '0);

        // Channel 0 P=10 paused four cycles at count 6.
        step(1'b0, 4'b0001, '0, '0, '0, per_of(0, 10));
        idle(4);
        for (int k = 0; k < 4; k++) step(1'b0, '0, '0, 4'b0001, '0, '0);
        idle(12);

        // Start with stop on channel 0, zero-period start on channel 3.
        step(1'b0, 4'b1001, 4'b0001, '0, 4'b1000, per_of(0, 7) | per_of(3, 0));
        idle(3);
        step(1'b0, '0, 4'b1111, '0, '0, '0);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [NUM_CH-1:0]       st, sp, ar;
            logic [NUM_CH*WIDTH-1:0] per;
            logic                    r;
            r = ($urandom_range(0, 499) == 0);
            per = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                st[ch] = ($urandom_range(0, 99) < 4);
                sp[ch] = ($urandom_range(0, 99) < 2);
                ar[ch] = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 99) < 10) pa_lvl[ch] = ~pa_lvl[ch];
                if ($urandom_range(0, 4) == 0)
                    per[ch*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 2));
                else
                    per[ch*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 40));
            end
            step(r, st, sp, pa_lvl, ar, per);
        end

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk_100Mhz);
        #2;
        if (sb_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expected snapshots left, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
